uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver, 8N1, LSB first, fixed baud given as clocks per bit.
//   Synchronises the asynchronous rx line, finds the start bit and samples each bit at mid-bit.
//   Presents each received byte with a one-cycle valid strobe, and flags bad stop bits.
//   Sits between the board RX pin and the byte-consuming logic.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal >= 4
// PORTS
//   clk          in   1  system clock
//   resetn       in   1  synchronous, active-low reset
//   rx_i         in   1  asynchronous serial input; idle high
//   d_o          out  8  last good byte; held until the next good byte
//   valid_o      out  1  1-cycle pulse: d_o updated with a new byte
//   frame_err_o  out  1  1-cycle pulse: stop bit sampled low; byte discarded
//   busy_o       out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset values
//   - d_o=0, valid_o=0, frame_err_o=0, busy_o=0, state=IDLE, bit_idx=0.
//   - Sync flops and edge-detect register reset to 1 (idle line).
//   Synchroniser and timer
//   - rx_i passes through 2 flops -> rx_s. All timing below is relative to rx_s.
//   - HALF = CLKS_PER_BIT/2 (integer division).
//   - timer is a down-counter, $clog2(CLKS_PER_BIT) bits wide.
//   - A "sample" occurs in the cycle timer==0; that cycle reloads timer to CLKS_PER_BIT-1.
//   - Sample points fall at HALF + k*CLKS_PER_BIT cycles after the start edge.
//   State machine
//   - IDLE -> START on a falling edge: rx_s_prev==1 and rx_s==0. Load timer=HALF-1.
//     A line held low (break) never re-triggers; it needs a high-then-low edge.
//   - START, at sample: rx_s==0 -> DATA, bit_idx=0. rx_s==1 -> IDLE (glitch).
//     A glitch gives no output pulse.
//   - DATA, at each sample: shift rx_s into shreg[bit_idx], bit_idx++.
//     After the sample with bit_idx==7 -> STOP.
//   - STOP, at sample, then -> IDLE:
//     rx_s==1: d_o<=shreg and valid_o=1 next cycle.
//     rx_s==0: frame_err_o=1 next cycle; d_o unchanged.
//   - valid_o and frame_err_o are registered and mutually exclusive; each is high for exactly 1 cycle.
//   Timing and boundaries
//   - Latency: valid_o rises HALF + 9*CLKS_PER_BIT + 1 cycles after the first cycle with rx_s==0.
//   - Back-to-back frames: the FSM is back in IDLE at mid stop bit, so the next start edge is caught.
//   - Reset asserted mid-frame: everything returns to reset values immediately.
//     A partial byte is dropped and gives no pulse.
// STRUCTURE
//   - uart_pkg holds: state localparams IDLE/START/DATA/STOP (3-bit, shared with the transmitter),
//     the default CLKS_PER_BIT, and 8N1 frame constants (DATA_BITS=8).
//   - One sub-module, sync_2ff: a 1-bit two-flop synchroniser with parameter RESET_VAL=1.
//     It is reused wherever asynchronous pins enter the design.
//   - The FSM, timer, shift register and output registers live in uart_rx itself.
// TESTING  (CLKS_PER_BIT=16 for sim speed; bits driven at exactly 16 clk)
//   1. Send 0xA5 -> one valid_o pulse, d_o=0xA5, frame_err_o never high;
//      latency = 8+9*16+1 cycles from the first rx_s low.
//   2. Send 0x00 then 0xFF back-to-back with no idle gap -> two valid_o pulses; d_o=0x00 then 0xFF.
//   3. Pull rx low for 5 cycles, then high -> no pulse, busy_o falls, state returns to IDLE.
//   4. Send 0x3C with stop bit 0 -> frame_err_o pulse, no valid_o, d_o keeps its previous value.
//      Hold the line low 100 cycles, then send 0x81 -> exactly one new frame, d_o=0x81.
//   5. Assert resetn=0 for 1 cycle during bit 4 of 0x55 -> no pulse for that byte, d_o=0;
//      the next frame 0x12 is received correctly.
//   6. Loopback from uart_tx at the same CLKS_PER_BIT, sending 256 random bytes
//      -> every byte matches, zero frame errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding (common to rx and tx), default baud
// divisor and 8N1 frame shape.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } uart_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; reset value selectable
// so idle-high lines come out of reset already idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect on the synchronised line, mid-bit
// sampling from a down-counter, one-cycle valid / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST    = 3'(DATA_BITS - 1);

  logic              rx_s, rx_prev;
  uart_state_t       state, state_d;
  logic [TW-1:0]     timer, timer_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        shreg, shreg_d;
  logic [7:0]        d_d;
  logic              valid_d, ferr_d;
  logic              tick;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx_i),
    .q      (rx_s)
  );

  assign tick   = (timer == '0);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_prev     <= 1'b1;
      d_o         <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      rx_prev     <= rx_s;
      d_o         <= d_d;
      valid_o     <= valid_d;
      frame_err_o <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    d_d       = d_o;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    // Free-running bit timer while a frame is in flight; reloads on each sample.
    if (state != IDLE)
      timer_d = tick ? RELOAD : timer - 1'b1;
    case (state)
      IDLE: begin
        // Needs a true high-to-low edge, so a held-low (break) line is ignored.
        if (rx_prev && !rx_s) begin
          state_d = START;
          timer_d = HALF_LD;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d[bit_idx] = rx_s;
          bit_idx_d        = bit_idx + 1'b1;
          if (bit_idx == LAST)
            state_d = STOP;
        end
      end
      STOP: begin
        // Back to IDLE at mid stop bit so a back-to-back start edge is caught.
        if (tick) begin
          state_d = IDLE;
          if (rx_s) begin
            d_d     = shreg;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes / frame errors,
// table of frames plus hand-written glitch, break, reset and random sequences.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx;
  logic [7:0] d_o;
  logic       valid_o, frame_err_o, busy_o;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
  } vec_t;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } ev_t;

  vec_t       vecs[7];
  ev_t        exp_q[$];
  ev_t        mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         start_cyc;
  int         last_valid_cyc;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_i        (rx),
    .d_o         (d_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    ev_t e;
    e.ferr = ~stop;
    e.data = d;
    exp_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected events never produced", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 0};
    vecs[2] = '{8'h5A, 1'b1, 3};
    vecs[3] = '{8'h01, 1'b1, 0};
    vecs[4] = '{8'h80, 1'b1, 0};
    vecs[5] = '{8'hC3, 1'b0, 4};
    vecs[6] = '{8'h7E, 1'b1, 0};

    resetn = 1'b0;
    rx     = 1'b1;

    fork
      begin
        forever begin
          @(negedge clk);
          if (resetn && (valid_o || frame_err_o)) begin
            checks++;
            if (valid_o && frame_err_o) begin
              failures++;
              $display("FAIL excl: valid_o and frame_err_o both high");
            end
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected: valid=%0b ferr=%0b d_o=0x%0h with nothing expected",
                       valid_o, frame_err_o, d_o);
            end else begin
              mon_e = exp_q.pop_front();
              checks++;
              if (frame_err_o !== mon_e.ferr) begin
                failures++;
                $display("FAIL kind: ferr=%0b expected ferr=%0b (byte 0x%0h)",
                         frame_err_o, mon_e.ferr, mon_e.data);
              end
              checks++;
              if (valid_o) begin
                if (d_o !== mon_e.data) begin
                  failures++;
                  $display("FAIL data: d_o=0x%0h expected 0x%0h", d_o, mon_e.data);
                end
                last_good      = mon_e.data;
                last_valid_cyc = cyc;
              end else if (d_o !== last_good) begin
                failures++;
                $display("FAIL hold: d_o=0x%0h after frame error, expected 0x%0h", d_o, last_good);
              end
            end
          end
        end
      end
      begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_d",     {24'h0, d_o},         32'h0);
    chk("rst_valid", {31'h0, valid_o},     32'h0);
    chk("rst_ferr",  {31'h0, frame_err_o}, 32'h0);
    chk("rst_busy",  {31'h0, busy_o},      32'h0);
    resetn = 1'b1;
    idle(4);

    // 1: single byte with latency from first synchronised low
    send_frame(8'hA5, 1'b1);
    idle(CPB);
    drain("t1_drain");
    chk("t1_d",       {24'h0, d_o}, 32'hA5);
    chk("t1_latency", last_valid_cyc - start_cyc, HALF + 9 * CPB + 1 + 2);

    // Table: back-to-back frames, gaps, a bad stop bit mid-stream
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    idle(CPB);
    drain("tbl_drain");
    chk("tbl_d", {24'h0, d_o}, 32'h7E);

    // 3: 5-cycle glitch
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", {31'h0, busy_o}, 32'h1);
    idle(2 * CPB);
    chk("glitch_busy_lo", {31'h0, busy_o}, 32'h0);
    chk("glitch_d",       {24'h0, d_o},    32'h7E);

    // 4: bad stop, then line held low (break), then a good frame
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    chk("break_busy", {31'h0, busy_o}, 32'h0);
    drain("t4_ferr");
    chk("t4_hold", {24'h0, d_o}, 32'h7E);
    idle(CPB);
    send_frame(8'h81, 1'b1);
    idle(CPB);
    drain("t4_drain");
    chk("t4_d", {24'h0, d_o}, 32'h81);

    // 5: reset in the middle of bit 4 of 0x55; sender aborts the frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5_busy", {31'h0, busy_o}, 32'h0);
    chk("t5_d",    {24'h0, d_o},    32'h0);
    last_good = 8'h00;
    idle(12 * CPB);
    chk("t5_d_after", {24'h0, d_o}, 32'h0);
    send_frame(8'h12, 1'b1);
    idle(CPB);
    drain("t5_drain");
    chk("t5_next", {24'h0, d_o}, 32'h12);

    // 6: 256 random bytes back-to-back
    for (int i = 0; i < 256; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    idle(2 * CPB);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
